// File: rtl/cu_sequencer_pkg.sv
// Shared defaults for the control-unit sequencer: widths, opcode names,
// default state encodings and the default opcode-to-start-state map.
package cu_pkg;

    localparam int CU_OPCODE_BITS = 2;
    localparam int CU_N           = 4;
    localparam int CU_NUM_STATES  = 9;

    typedef enum logic [CU_OPCODE_BITS-1:0] {
        OP_ADD = 2'd0,
        OP_AND = 2'd1,
        OP_JMP = 2'd2,
        OP_INC = 2'd3
    } cu_opcode_e;

    localparam logic [CU_N-1:0] FETCH1 = 4'd0;
    localparam logic [CU_N-1:0] FETCH2 = 4'd1;
    localparam logic [CU_N-1:0] FETCH3 = 4'd2;
    localparam logic [CU_N-1:0] ADD1   = 4'd3;
    localparam logic [CU_N-1:0] ADD2   = 4'd4;
    localparam logic [CU_N-1:0] AND1   = 4'd5;
    localparam logic [CU_N-1:0] AND2   = 4'd6;
    localparam logic [CU_N-1:0] JMP1   = 4'd7;
    localparam logic [CU_N-1:0] INC1   = 4'd8;

    // Opcode k's start state sits at bits [k*N +: N].
    localparam logic [CU_N*(2**CU_OPCODE_BITS)-1:0] CU_START_MAP = {INC1, JMP1, AND1, ADD1};

endpackage

// File: rtl/cu_state_decoder.sv
// One-hot decode of the sequencer state plus a fetch-state flag.
// Out-of-range state values decode to all zeros.
module cu_state_decoder #(
    parameter int N           = 4,
    parameter int NUM_STATES  = 9,
    parameter int FETCH_STATE = 0
) (
    input  logic [N-1:0]          q_i,
    output logic [NUM_STATES-1:0] state_oh_o,
    output logic                  at_fetch_o
);

    for (genvar i = 0; i < NUM_STATES; i++) begin : g_oh
        assign state_oh_o[i] = (q_i == N'(i));
    end

    assign at_fetch_o = (q_i == N'(FETCH_STATE));

endmodule

// File: rtl/cu_sequencer.sv
// Control-unit state sequencer: dispatch, increment, branch, clear and stall.
// Define CU_SEQ_TRAP_EN to trap illegal events into a sticky err flag.
module cu_sequencer
    import cu_pkg::*;
#(
    parameter int OPCODE_BITS = CU_OPCODE_BITS,
    parameter int N           = CU_N,
    parameter int NUM_STATES  = CU_NUM_STATES,
    parameter int FETCH_STATE = 0,
    parameter logic [N*(2**OPCODE_BITS)-1:0] START_MAP = CU_START_MAP
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [OPCODE_BITS-1:0] opcode,
    input  logic                   load,
    input  logic                   inc,
    input  logic                   clr,
    input  logic                   br,
    input  logic [N-1:0]           br_target,
    input  logic                   stall,
    output logic [N-1:0]           q,
    output logic [OPCODE_BITS-1:0] opcode_q,
    output logic [NUM_STATES-1:0]  state_oh,
    output logic                   at_fetch,
    output logic                   err
);

    localparam logic [N-1:0] FETCH_W = N'(FETCH_STATE);
    localparam logic [N-1:0] LAST_W  = N'(NUM_STATES - 1);
    localparam logic [N:0]   NS_W    = (N+1)'(NUM_STATES);

    logic [N-1:0]           state_q, state_d;
    logic [OPCODE_BITS-1:0] op_q, op_d;
    logic [N-1:0]           map_entry;
    logic [N:0]             inc_sum;
    logic                   map_ok, br_ok, inc_ok;

    assign map_entry = START_MAP[int'(opcode)*N +: N];
    assign map_ok    = ({1'b0, map_entry} < NS_W);
    assign br_ok     = ({1'b0, br_target} < NS_W);
    // Widened so an all-ones state cannot wrap back into the legal range.
    assign inc_sum   = {1'b0, state_q} + (N+1)'(1);
    assign inc_ok    = (inc_sum < NS_W);

`ifdef CU_SEQ_TRAP_EN
    logic err_q, err_d, illegal;
    assign illegal = (load && (!map_ok || br || inc))
                   || (!load && br && !br_ok)
                   || (!load && !br && inc && (state_q == LAST_W));
    assign err = err_q;
`else
    assign err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
`ifdef CU_SEQ_TRAP_EN
        err_d   = err_q;
`endif
        if (clr) begin
            state_d = FETCH_W;
            op_d    = '0;
`ifdef CU_SEQ_TRAP_EN
            err_d   = 1'b0;
`endif
        end else if (!stall) begin
`ifdef CU_SEQ_TRAP_EN
            if (illegal) err_d = 1'b1;
            else
`endif
            if (load) begin
                op_d    = opcode;
                state_d = map_ok ? map_entry : FETCH_W;
            end else if (br) begin
                if (br_ok) state_d = br_target;
            end else if (inc) begin
                state_d = inc_ok ? inc_sum[N-1:0] : FETCH_W;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FETCH_W;
            op_q    <= '0;
`ifdef CU_SEQ_TRAP_EN
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
`ifdef CU_SEQ_TRAP_EN
            err_q   <= err_d;
`endif
        end
    end

    assign q        = state_q;
    assign opcode_q = op_q;

    cu_state_decoder #(
        .N           (N),
        .NUM_STATES  (NUM_STATES),
        .FETCH_STATE (FETCH_STATE)
    ) u_decoder (
        .q_i        (state_q),
        .state_oh_o (state_oh),
        .at_fetch_o (at_fetch)
    );

endmodule

// File: tb/tb_cu_sequencer.sv
// Scoreboard bench for cu_sequencer: stimulus pushes hand-computed expectations,
// a monitor pops and compares one entry after every clock edge.
module tb_cu_sequencer;

`ifdef CU_SEQ_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic [1:0] opcode;
    logic       load, inc, clr, br, stall;
    logic [3:0] br_target;
    logic [3:0] q;
    logic [1:0] opcode_q;
    logic [8:0] state_oh;
    logic       at_fetch;
    logic       err;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [3:0] q;
        logic [1:0] op;
        logic       err;
        string      nm;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    cu_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .opcode    (opcode),
        .load      (load),
        .inc       (inc),
        .clr       (clr),
        .br        (br),
        .br_target (br_target),
        .stall     (stall),
        .q         (q),
        .opcode_q  (opcode_q),
        .state_oh  (state_oh),
        .at_fetch  (at_fetch),
        .err       (err)
    );

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endfunction

    function automatic logic [8:0] oh_of(logic [3:0] v);
        logic [8:0] one;
        one = 9'd1;
        return (v < 4'd9) ? (one << v) : 9'd0;
    endfunction

    function automatic void chk_all(string nm, logic [3:0] eq, logic [1:0] eop, logic eerr);
        chk({nm, ".q"},        32'(q),        32'(eq));
        chk({nm, ".opcode_q"}, 32'(opcode_q), 32'(eop));
        chk({nm, ".state_oh"}, 32'(state_oh), 32'(oh_of(eq)));
        chk({nm, ".at_fetch"}, 32'(at_fetch), 32'(eq == 4'd0));
        chk({nm, ".err"},      32'(err),      32'(eerr));
    endfunction

    task automatic drive(input logic l, input logic i, input logic c, input logic b,
                         input logic s, input logic [1:0] op, input logic [3:0] bt);
        load = l; inc = i; clr = c; br = b; stall = s; opcode = op; br_target = bt;
    endtask

    // One edge of stimulus with the state expected right after that edge.
    task automatic step(input logic l, input logic i, input logic c, input logic b,
                        input logic s, input logic [1:0] op, input logic [3:0] bt,
                        input logic [3:0] eq, input logic [1:0] eop, input logic eerr,
                        input string nm);
        exp_t e;
        @(negedge clk);
        drive(l, i, c, b, s, op, bt);
        e.q = eq; e.op = eop; e.err = eerr; e.nm = nm;
        sb.push_back(e);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_all(e.nm, e.q, e.op, e.err);
            end
        end
    end

    initial begin : stimulus
        logic [3:0] st [4];
        logic [3:0] nx [4];
        int wait_cycles;
        st[0] = 4'd3; st[1] = 4'd5; st[2] = 4'd7; st[3] = 4'd8;
        nx[0] = 4'd4; nx[1] = 4'd6; nx[2] = 4'd8; nx[3] = 4'd0;

        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 2'd0, 4'd0);
        repeat (2) @(posedge clk);
        #1 chk_all("reset", 4'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;

        //    ld i  c  b  s  op    bt     q      op    err
        step(0, 1, 0, 0, 0, 2'd0, 4'd0,  4'd1,  2'd0, 0, "walk1");
        step(0, 1, 0, 0, 0, 2'd0, 4'd0,  4'd2,  2'd0, 0, "walk2");
        step(0, 1, 0, 0, 0, 2'd0, 4'd0,  4'd3,  2'd0, 0, "walk3");
        step(0, 0, 1, 0, 0, 2'd0, 4'd0,  4'd0,  2'd0, 0, "walk_clr");

        for (int k = 0; k < 4; k++) begin
            step(1, 0, 0, 0, 0, 2'(k), 4'd0, st[k], 2'(k), 0, $sformatf("dispatch%0d", k));
            step(0, 1, 0, 0, 0, 2'(k), 4'd0,
                 (k == 3 && TRAP) ? 4'd8 : nx[k], 2'(k), (k == 3) && TRAP,
                 $sformatf("dispatch%0d_inc", k));
            step(0, 0, 1, 0, 0, 2'd0, 4'd0, 4'd0, 2'd0, 0, $sformatf("dispatch%0d_clr", k));
        end

        step(1, 1, 0, 0, 0, 2'd2, 4'd0, TRAP ? 4'd0 : 4'd7, TRAP ? 2'd0 : 2'd2, TRAP, "load_inc");
        step(0, 0, 1, 0, 0, 2'd0, 4'd0,  4'd0,  2'd0, 0, "load_inc_clr");
        step(1, 0, 0, 0, 0, 2'd1, 4'd0,  4'd5,  2'd1, 0, "pre_stall");
        step(1, 0, 0, 0, 1, 2'd3, 4'd0,  4'd5,  2'd1, 0, "stall_load");
        step(0, 1, 0, 0, 1, 2'd0, 4'd0,  4'd5,  2'd1, 0, "stall_inc");
        step(0, 0, 1, 0, 1, 2'd0, 4'd0,  4'd0,  2'd0, 0, "clr_stall");

        step(0, 0, 0, 1, 0, 2'd0, 4'd5,  4'd5,  2'd0, 0, "br5");
        step(0, 1, 0, 1, 0, 2'd0, 4'd2,  4'd2,  2'd0, 0, "br_inc");
        step(0, 0, 0, 1, 0, 2'd0, 4'd12, 4'd2,  2'd0, TRAP, "br12");
        step(0, 1, 0, 0, 0, 2'd0, 4'd0,  4'd3,  2'd0, TRAP, "br12_sticky");
        step(0, 0, 1, 0, 0, 2'd0, 4'd0,  4'd0,  2'd0, 0, "br12_clr");

        step(0, 0, 0, 1, 0, 2'd0, 4'd8,  4'd8,  2'd0, 0, "br8");
        step(0, 1, 0, 0, 0, 2'd0, 4'd0,  TRAP ? 4'd8 : 4'd0, 2'd0, TRAP, "wrap");
        step(0, 0, 1, 0, 0, 2'd0, 4'd0,  4'd0,  2'd0, 0, "wrap_clr");

        step(0, 0, 0, 1, 0, 2'd0, 4'd6,  4'd6,  2'd0, 0, "br6");
        step(0, 0, 0, 0, 0, 2'd0, 4'd0,  4'd6,  2'd0, 0, "idle_hold");

        step(1, 0, 0, 0, 0, 2'd1, 4'd0,  4'd5,  2'd1, 0, "pre_rst_load");
        step(0, 1, 0, 0, 0, 2'd1, 4'd0,  4'd6,  2'd1, 0, "pre_rst_inc");
        @(posedge clk);
        #2;
        drive(0, 0, 0, 0, 0, 2'd0, 4'd0);
        rst_n = 1'b0;
        #1 chk_all("async_rst", 4'd0, 2'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 1, 0, 0, 0, 2'd0, 4'd0,  4'd1,  2'd0, 0, "post_rst_inc");
        step(0, 0, 0, 0, 0, 2'd0, 4'd0,  4'd1,  2'd0, 0, "post_rst_hold");

        wait_cycles = 0;
        while (sb.size() > 0 && wait_cycles < 20) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cu_sequencer.md
Name: cu_sequencer

Overview:
- Parametrised control-unit state sequencer, successor to the fixed 2-bit-opcode / 9-state counter.
- Holds the current control state and the latched opcode.
- Dispatches to a per-opcode start state taken from a parameter map; also supports increment, clear-to-fetch, direct branch and stall.
- Also provides a one-hot state decode to drive the control-signal logic. Sits between the instruction register and the CU signal decoder.

Parameters:
- OPCODE_BITS, 2, opcode width; map holds 2**OPCODE_BITS entries.
- N, 4, state register width.
- NUM_STATES, 9, legal states 0..NUM_STATES-1; NUM_STATES must be <= 2**N.
- FETCH_STATE, 0, state entered on reset and clr.
- START_MAP, 16'h8753, packed start states, N bits per opcode, opcode k at bits [k*N +: N]. Default: 00->3, 01->5, 10->7, 11->8.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- opcode  in  OPCODE_BITS  opcode to dispatch on
- load  in  1  latch opcode, jump to its mapped start state
- inc  in  1  advance to next state
- clr  in  1  return to FETCH_STATE, clear opcode_q
- br  in  1  jump to br_target
- br_target  in  N  branch destination
- stall  in  1  hold all registers (memory wait)
- q  out  N  current state (registered)
- opcode_q  out  OPCODE_BITS  latched opcode (registered)
- state_oh  out  NUM_STATES  one-hot of q (combinational from q)
- at_fetch  out  1  q == FETCH_STATE (combinational)
- err  out  1  sticky error flag (CU_SEQ_TRAP_EN only, else tied 0)

Behaviour:
- Reset (rst_n low, asynchronous): q=FETCH_STATE, opcode_q=0, err=0. Therefore state_oh has only bit FETCH_STATE set and at_fetch=1. Reset mid-sequence aborts immediately. First update occurs on the first rising edge after rst_n deasserts.
- Per-edge priority, highest first: clr > stall > load > br > inc > hold.
- clr: q=FETCH_STATE, opcode_q=0. clr overrides stall.
- stall: q and opcode_q hold regardless of load/br/inc.
- load: opcode_q=opcode; q=START_MAP[opcode*N +: N]. Takes effect in one cycle, so q shows the start state on the next edge.
- br: q=br_target if br_target < NUM_STATES; otherwise q holds.
- inc: q=q+1 if q < NUM_STATES-1. At q==NUM_STATES-1, q wraps to FETCH_STATE.
- Simultaneous load+inc (undefined in the previous generation): load wins, inc is ignored.
- Simultaneous br+inc: br wins.
- No inputs asserted: hold.
- Map entries >= NUM_STATES: q loads FETCH_STATE instead.
- Bits of state_oh for values >= NUM_STATES are never set. An out-of-range q (unreachable without trap) gives all-zero state_oh.
- Arithmetic is N-bit unsigned; the increment is computed N+1 wide so that q == 2**N - 1 cannot silently overflow.

Optional Feature:
- Macro: CU_SEQ_TRAP_EN.
- Defined: any illegal event sets err=1 and holds q and opcode_q that cycle. Illegal events are:
  - inc at NUM_STATES-1;
  - br with br_target >= NUM_STATES;
  - load whose map entry >= NUM_STATES;
  - load and br (or load and inc) asserted together.
- err is sticky; cleared only by rst_n or clr. clr still performs its normal action.
- Not defined: err tied 0; wrap, ignore and priority rules above apply.

Decomposition:
- Package cu_pkg:
  - default OPCODE_BITS, N, NUM_STATES;
  - typedef enum for the default opcodes (OP_ADD, OP_AND, OP_JMP, OP_INC);
  - localparams for the default state encodings (FETCH1=0 .. INC1=8);
  - default START_MAP constant.
- Sub-module cu_state_decoder (parametrised N, NUM_STATES): q -> state_oh, at_fetch. Purely combinational; instantiated once.

Test Plan:
- Reset: hold rst_n=0 mid-sequence at q=6 -> q=0, opcode_q=0, state_oh=9'b000000001, at_fetch=1 asynchronously, before the next clk edge.
- Dispatch: for each opcode, load=1 with opcode=0/1/2/3 -> q=3/5/7/8 one edge later, opcode_q=opcode; then inc -> 4/6/8/0.
- Fetch walk: from reset, inc x3 -> q=1,2,3; clr -> q=0, opcode_q=0.
- Priority: load+inc with opcode=2 -> q=7 (trap build: err=1, q holds). stall+load -> hold. clr+stall -> q=0.
- Branch: br=1, br_target=5 -> q=5. br_target=12 -> q holds (trap build: err=1 until clr).
- Wrap/trap: q=8, inc -> q=0, err=0. In a CU_SEQ_TRAP_EN build, q=8, inc -> q stays 8, err=1; then clr -> q=0, err=0.
